// File: rtl/apb_req_arbiter_if.sv
// Request/response and APB bus signals shared between the arbiter and its environment.
// The master modport is the arbiter's view; the slave modport is the requesters plus the APB slave.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic                          PSEL;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [ADDR_WIDTH-1:0]         PADDR;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PREADY;
    logic                          PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: APB master front end sharing one APB bus among NUM_REQ requesters.
// Round-robin grant, SETUP/ACCESS sequencing with PREADY wait states, and a wait-cycle
// timeout that aborts a hung transfer and reports it as an error to the owner.
module apb_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_req_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   grant_found;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_window;
    logic                   grant_take;
    logic [NUM_REQ-1:0]     req_ready_c;
    int                     cand;
    logic [IDX_W-1:0]       cand_idx;

    // Round-robin search for the first pending requester, starting at the pointer
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A new transfer can be accepted when idle or in the completing ACCESS cycle, never in reset
    always_comb begin
        grant_window = PRESETn && ((state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY));
        grant_take   = grant_window && grant_found;
        req_ready_c  = '0;
        if (grant_take) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    // Next state, request latching, wait-cycle counting and response capture
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = write_q ? '0 : bus.PRDATA;
                    rsp_err_d            = bus.PSLVERR;
                    state_d              = IDLE;
                end else if (cnt_q == CNT_LIMIT) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                    cnt_d                = cnt_q + CNT_W'(1);
                    state_d              = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_take) begin
            write_d = bus.req_write[grant_idx];
            addr_d  = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d = bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            owner_d = grant_idx;
            rr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
            cnt_d   = '0;
            state_d = SETUP;
        end
    end

    // State, latched request and registered response
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.PSEL      = (state_q != IDLE);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PWRITE    = write_q;
    assign bus.PADDR     = addr_q;
    assign bus.PWDATA    = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Testbench for apb_req_arbiter: two request agents, an APB SRAM slave with scripted wait
// states, a transaction-level reference model and a response scoreboard.
module tb_apb_req_arbiter;
    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
    } op_t;

    typedef struct {
        int          req;
        logic [31:0] rdata;
        logic        err;
        longint      cyc;
    } rsp_t;

    logic PCLK;
    logic PRESETn;

    apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .bus(bus)
    );

    int           compared;
    int           mismatched;
    longint       cyc;
    op_t          q0[$];
    op_t          q1[$];
    rsp_t         sb[$];
    int           plan[$];
    logic [NUM_REQ-1:0] drv_valid;
    op_t          dop;
    logic [31:0]  ref_mem [logic [31:0]];
    logic [31:0]  slv_mem [logic [31:0]];
    int           s_wait;
    int           s_acc;
    int           rr;
    longint       free_cyc;
    longint       end_cyc;
    longint       grant_cyc;
    op_t          cur_op;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [31:0] defaultWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic isErrAddr(input logic [31:0] a);
        return a >= 32'h0000_FFF0;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic op_t qhead(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) q0.delete(0);
        else        q1.delete(0);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int req, input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits);
        op_t o;
        o.write = write;
        o.addr  = addr;
        o.wdata = wdata;
        o.waits = waits;
        if (req == 0) q0.push_back(o);
        else          q1.push_back(o);
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + sb.size() > 0) && n < limit) begin
            @(posedge PCLK);
            n++;
        end
        if (n >= limit) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d cycles elapsed, queues still busy", n);
        end
        @(posedge PCLK);
    endtask

    // Request agents present the head of their queue, junk on the bus fields when idle
    always @(posedge PCLK) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (qsize(i) > 0) begin
                dop = qhead(i);
                drv_valid[i]            = 1'b1;
                bus.req_write[i]        = dop.write;
                bus.req_addr[i*AW +: AW] = dop.addr;
                bus.req_wdata[i*DW +: DW] = dop.wdata;
            end else begin
                drv_valid[i]            = 1'b0;
                bus.req_write[i]        = 1'($urandom);
                bus.req_addr[i*AW +: AW] = $urandom;
                bus.req_wdata[i*DW +: DW] = $urandom;
            end
        end
        bus.req_valid = drv_valid;
    end

    // APB SRAM slave: wait count per transfer comes from the plan queue, errors above 0xFFF0
    always @(posedge PCLK) begin
        #1;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = $urandom;
        if (bus.PSEL && !bus.PENABLE) begin
            s_wait = 0;
            if (plan.size() > 0) s_wait = plan.pop_front();
            s_acc = 0;
        end else if (bus.PSEL && bus.PENABLE) begin
            if (s_acc >= s_wait) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = isErrAddr(bus.PADDR);
                if (bus.PWRITE) begin
                    if (!isErrAddr(bus.PADDR)) slv_mem[bus.PADDR] = bus.PWDATA;
                end else begin
                    bus.PRDATA = slv_mem.exists(bus.PADDR) ? slv_mem[bus.PADDR]
                                                           : defaultWord(bus.PADDR);
                end
            end else begin
                s_acc++;
            end
        end
    end

    // Reference model: transfer timeline, bus phase checks, round-robin grant prediction
    always @(negedge PCLK) begin
        logic               exp_psel;
        logic               exp_pen;
        logic [NUM_REQ-1:0] exp_ready;
        int                 win;
        int                 idx;
        rsp_t               r;
        if (PRESETn) begin
            exp_psel = (cyc > grant_cyc) && (cyc <= end_cyc);
            exp_pen  = exp_psel && (cyc >= grant_cyc + 2);
            checkOutput("PSEL", 64'(bus.PSEL), 64'(exp_psel));
            checkOutput("PENABLE", 64'(bus.PENABLE), 64'(exp_pen));
            if (exp_psel) begin
                checkOutput("PADDR", 64'(bus.PADDR), 64'(cur_op.addr));
                checkOutput("PWRITE", 64'(bus.PWRITE), 64'(cur_op.write));
                checkOutput("PWDATA", 64'(bus.PWDATA), 64'(cur_op.wdata));
            end

            exp_ready = '0;
            win = -1;
            if (cyc >= free_cyc) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (rr + k) % NUM_REQ;
                    if (win < 0 && drv_valid[idx]) win = idx;
                end
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));

            if (win >= 0) begin
                cur_op    = qhead(win);
                qpop(win);
                grant_cyc = cyc;
                rr        = (win + 1) % NUM_REQ;
                plan.push_back(cur_op.waits);
                r.req = win;
                if (cur_op.waits >= TIMEOUT) begin
                    r.err    = 1'b1;
                    r.rdata  = 32'h0;
                    r.cyc    = cyc + 2 + TIMEOUT;
                    end_cyc  = cyc + 1 + TIMEOUT;
                    free_cyc = cyc + 2 + TIMEOUT;
                end else begin
                    r.err = isErrAddr(cur_op.addr);
                    if (cur_op.write) begin
                        r.rdata = 32'h0;
                        if (!r.err) ref_mem[cur_op.addr] = cur_op.wdata;
                    end else begin
                        r.rdata = ref_mem.exists(cur_op.addr) ? ref_mem[cur_op.addr]
                                                              : defaultWord(cur_op.addr);
                    end
                    r.cyc    = cyc + 3 + cur_op.waits;
                    end_cyc  = cyc + 2 + cur_op.waits;
                    free_cyc = cyc + 2 + cur_op.waits;
                end
                sb.push_back(r);
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents a completion
    always @(negedge PCLK) begin
        rsp_t               r;
        logic [NUM_REQ-1:0] exp_v;
        if (PRESETn) begin
            if (bus.rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    r = sb.pop_front();
                    exp_v = '0;
                    exp_v[r.req] = 1'b1;
                    checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
                    checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
                    checkOutput("rsp_err", 64'(bus.rsp_err), 64'(r.err));
                    checkOutput("rsp_cycle", 64'(cyc), 64'(r.cyc));
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                r = sb.pop_front();
                exp_v = '0;
                exp_v[r.req] = 1'b1;
                checkOutput("rsp_missing", 64'(bus.rsp_valid), 64'(exp_v));
            end
        end
    end

    // Safety net against a hung simulation
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed scenarios, randomized traffic, then a mid-transfer reset
    initial begin
        int n;
        int sel;
        int w;
        compared      = 0;
        mismatched    = 0;
        cyc           = 0;
        rr            = 0;
        free_cyc      = 0;
        end_cyc       = -1;
        grant_cyc     = -10;
        s_wait        = 0;
        s_acc         = 0;
        drv_valid     = '0;
        PRESETn       = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = '0;

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checkOutput("reset_PSEL", 64'(bus.PSEL), 64'(0));
        checkOutput("reset_PENABLE", 64'(bus.PENABLE), 64'(0));
        checkOutput("reset_PWRITE", 64'(bus.PWRITE), 64'(0));
        checkOutput("reset_PADDR", 64'(bus.PADDR), 64'(0));
        checkOutput("reset_PWDATA", 64'(bus.PWDATA), 64'(0));
        checkOutput("reset_req_ready", 64'(bus.req_ready), 64'(0));
        checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        checkOutput("reset_rsp_err", 64'(bus.rsp_err), 64'(0));
        @(posedge PCLK);
        #2 PRESETn = 1'b1;
        @(posedge PCLK);

        $display("[TB] single write, zero wait");
        applyStimulus(0, 1'b1, 32'h10, 32'hA5A5_0001, 0);
        waitDrain(100);

        $display("[TB] read back with three wait states");
        applyStimulus(1, 1'b0, 32'h10, $urandom, 3);
        waitDrain(100);

        $display("[TB] both requesters, four transfers each");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b1, 32'h20 + 32'(k*4), $urandom, 0);
            applyStimulus(1, 1'b0, 32'h20 + 32'(k*4), $urandom, 0);
        end
        waitDrain(200);

        $display("[TB] longest wait that still completes");
        applyStimulus(0, 1'b0, 32'h24, $urandom, TIMEOUT - 1);
        waitDrain(100);

        $display("[TB] hung transfer aborted, followed by normal traffic");
        applyStimulus(0, 1'b0, 32'h30, $urandom, 1000);
        applyStimulus(1, 1'b1, 32'h30, 32'h1234_5678, 0);
        applyStimulus(0, 1'b0, 32'h30, $urandom, 0);
        waitDrain(200);

        $display("[TB] slave error on 0xFFF0");
        applyStimulus(1, 1'b0, 32'hFFF0, $urandom, 0);
        applyStimulus(1, 1'b1, 32'hFFF4, $urandom, 1);
        waitDrain(100);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 15);
            if (sel < 8)       w = 0;
            else if (sel < 13) w = $urandom_range(1, 4);
            else if (sel < 15) w = $urandom_range(5, TIMEOUT - 1);
            else               w = TIMEOUT + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)
                applyStimulus($urandom_range(0, 1), 1'($urandom), 32'hFFF0 + 32'($urandom_range(0, 3) * 4),
                              $urandom, w);
            else
                applyStimulus($urandom_range(0, 1), 1'($urandom), 32'($urandom_range(0, 15) * 4),
                              $urandom, w);
            repeat ($urandom_range(0, 3)) @(posedge PCLK);
        end
        waitDrain(5000);

        $display("[TB] reset during ACCESS");
        applyStimulus(0, 1'b0, 32'h24, $urandom, 1000);
        n = 0;
        while (sb.size() == 0 && n < 50) begin
            @(posedge PCLK);
            n++;
        end
        if (n >= 50) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL grant_timeout: no grant after %0d cycles", n);
        end
        repeat (4) @(posedge PCLK);
        #3 PRESETn = 1'b0;
        #1;
        checkOutput("async_reset_PSEL", 64'(bus.PSEL), 64'(0));
        checkOutput("async_reset_PENABLE", 64'(bus.PENABLE), 64'(0));
        checkOutput("async_reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("async_reset_req_ready", 64'(bus.req_ready), 64'(0));
        sb.delete();
        plan.delete();
        rr        = 0;
        free_cyc  = 0;
        end_cyc   = -1;
        grant_cyc = -10;
        applyStimulus(1, 1'b0, 32'h10, $urandom, 0);
        applyStimulus(0, 1'b0, 32'h14, $urandom, 0);
        repeat (2) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        waitDrain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
